lfsr_prbs_gen_check: RTL and testbench
======================================

Name: lfsr_prbs_gen_check

Overview:
Parametrised Galois LFSR pattern generator with a companion self-synchronising pattern checker. Both share one polynomial and one clock. Generator replaces the fixed 8-bit LFSR generator as the PRBS source for link and datapath tests. Checker receives words on the far side, locks onto the stream, and counts bit-word errors for BER-style tests.

Parameters:
WIDTH, 8, LFSR state, output and checker data width (3..32)
TAPS, 8'hB8, Galois feedback mask, WIDTH bits; default is maximal length for WIDTH=8 (period 255)
LOCK_CNT, 4, consecutive correct predictions needed to enter LOCKED (>=1)
UNLOCK_CNT, 4, consecutive mismatches in LOCKED that force return to SEARCH (>=1)
ERR_W, 16, error counter width

Ports:
clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous reset, active-low
i_soft_reset  in  1  synchronous: loads i_seed into generator, returns checker to SEARCH, clears error counter
i_seed  in  WIDTH  generator seed
i_valid  in  1  generator advance enable
o_lfsr  out  WIDTH  generator state / output word
i_chk_valid  in  1  checker input word valid
i_chk_data  in  WIDTH  checker input word
o_lock  out  1  checker in LOCKED state
o_err_pulse  out  1  one-cycle pulse per mismatched word while LOCKED
o_err_count  out  ERR_W  saturating count of mismatched words while LOCKED

Behaviour:
- step(s) = (s >> 1) ^ (s[0] ? TAPS : 0), all WIDTH bits.
- i_rst low: o_lfsr = all ones, checker state SEARCH, expected = 0, match/bad counters 0, o_lock = 0, o_err_pulse = 0, o_err_count = 0. Takes effect immediately, independent of clk.
- Generator, per rising edge, priority order:
  - i_soft_reset=1: o_lfsr <= i_seed; if i_seed == 0, load all ones instead (lock-up state forbidden). i_valid ignored this cycle.
  - else i_valid=1: o_lfsr <= step(o_lfsr).
  - else hold.
- Latency: o_lfsr shows the new word on the edge that samples i_valid=1. No output valid flag; consumer samples o_lfsr after that edge.
- Checker FSM, evaluated only on edges with i_chk_valid=1; otherwise everything holds and o_err_pulse=0.
  - i_soft_reset=1: state SEARCH, counters cleared, o_err_count=0, o_lock=0. Overrides i_chk_valid.
  - SEARCH:
    - i_chk_data == 0: stay in SEARCH.
    - otherwise: expected <= step(i_chk_data), match_cnt <= 0, go to VERIFY.
  - VERIFY:
    - data == expected: expected <= step(data), match_cnt++; when match_cnt+1 == LOCK_CNT, go to LOCKED, bad_cnt <= 0.
    - mismatch: reseed expected <= step(data) (or go to SEARCH if data == 0), match_cnt <= 0, stay in VERIFY. No error counted.
  - LOCKED:
    - expected <= step(expected) every valid word, so a single bad word does not resync.
    - match: bad_cnt <= 0.
    - mismatch: o_err_pulse=1 next cycle, o_err_count++ (saturates at all ones, no wrap), bad_cnt++; when bad_cnt+1 == UNLOCK_CNT, go to SEARCH.
- o_lock, o_err_pulse, o_err_count are registered and update on the same edge as the state change.
- Lock acquisition from a clean stream: word 1 seeds, words 2..LOCK_CNT+1 verify; o_lock rises on the edge sampling word LOCK_CNT+1.
- Generator and checker are independent apart from the shared soft reset. External loopback of o_lfsr to i_chk_data is the self-test configuration.
- Non-maximal TAPS values are legal. Period is then TAPS-dependent; the block does not check it.

Test Plan:
- Seed/sequence: i_seed=8'h01, soft reset, 4 i_valid pulses -> o_lfsr = 01, B8, 5C, 2E, 17; the following pulse gives B3; with i_valid low between pulses, o_lfsr holds.
- Zero seed and priority: i_seed=0 with i_soft_reset=1 and i_valid=1 in the same cycle -> o_lfsr=FF (no advance). Separately, seed 8'hA5 plus 255 valid pulses -> o_lfsr returns to A5 exactly at pulse 255, never earlier, and never equals 0.
- Loopback lock: o_lfsr fed to checker with i_chk_valid=i_valid from seed 01 -> o_lock rises on the 5th valid word; o_err_count stays 0 over 1000 words.
- Error injection: once locked, flip bit 3 of one word -> exactly one o_err_pulse, o_err_count=1, o_lock stays 1. Then corrupt 4 consecutive words -> o_err_count=5, o_lock=0, relock after 5 further clean words.
- Saturation: ERR_W=3, locked, UNLOCK_CNT=100, alternating bad and good words -> o_err_count reaches 7 and holds.
- Reset mid-operation: assert i_rst low between clock edges while locked -> o_lock=0, o_err_count=0, o_lfsr=FF immediately. After release, relock occurs with normal 5-word latency. WIDTH=16, TAPS=16'hB400 also passes loopback with no errors over 65535 words.

Source files
------------

// File: rtl/lfsr_prbs_gen_check_if.sv
// Bundle of generator and checker signals for lfsr_prbs_gen_check.
//   i_soft_reset : synchronous reseed of generator, checker back to SEARCH
//   i_seed       : generator seed (zero is replaced by all ones)
//   i_valid      : generator advance enable
//   o_lfsr       : generator state / output word
//   i_chk_valid  : checker input word valid
//   i_chk_data   : checker input word
//   o_lock       : checker locked
//   o_err_pulse  : one-cycle pulse per mismatched word while locked
//   o_err_count  : saturating mismatch count while locked
// master drives the inputs (producer/test side); slave is the block itself.
interface lfsr_prbs_gen_check_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 16
);
  logic             i_soft_reset;
  logic [WIDTH-1:0] i_seed;
  logic             i_valid;
  logic [WIDTH-1:0] o_lfsr;
  logic             i_chk_valid;
  logic [WIDTH-1:0] i_chk_data;
  logic             o_lock;
  logic             o_err_pulse;
  logic [ERR_W-1:0] o_err_count;

  modport master (
    output i_soft_reset, i_seed, i_valid, i_chk_valid, i_chk_data,
    input  o_lfsr, o_lock, o_err_pulse, o_err_count
  );

  modport slave (
    input  i_soft_reset, i_seed, i_valid, i_chk_valid, i_chk_data,
    output o_lfsr, o_lock, o_err_pulse, o_err_count
  );
endinterface

// File: rtl/lfsr_prbs_gen_check.sv
// Galois LFSR PRBS generator plus a self-synchronising pattern checker sharing
// one feedback polynomial (TAPS).
//   clk   : rising-edge clock
//   i_rst : asynchronous active-low reset
//   bus   : lfsr_prbs_gen_check_if.slave (generator and checker signals)
// The checker seeds its prediction from a received word, needs LOCK_CNT
// consecutive correct predictions to lock, and once locked free-runs its
// prediction so isolated bad words are counted instead of causing a resync.
module lfsr_prbs_gen_check #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter int unsigned      LOCK_CNT   = 4,
  parameter int unsigned      UNLOCK_CNT = 4,
  parameter int unsigned      ERR_W      = 16
) (
  input logic                  clk,
  input logic                  i_rst,
  lfsr_prbs_gen_check_if.slave bus
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BadW   = $clog2(UNLOCK_CNT + 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [BadW-1:0]   BadLast   = BadW'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // Generator
  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.i_soft_reset) begin
      // All-zero is the lock-up state of the LFSR; never load it.
      lfsr_d = (bus.i_seed == '0) ? '1 : bus.i_seed;
    end else if (bus.i_valid) begin
      lfsr_d = step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) lfsr_q <= '1;
    else        lfsr_q <= lfsr_d;
  end

  assign bus.o_lfsr = lfsr_q;

  // Checker
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic [MatchW-1:0] match_cnt_q, match_cnt_d;
  logic [BadW-1:0]   bad_cnt_q, bad_cnt_d;
  logic              lock_q, lock_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (bus.i_soft_reset) begin
      state_d     = StSearch;
      expected_d  = '0;
      match_cnt_d = '0;
      bad_cnt_d   = '0;
      err_count_d = '0;
    end else if (bus.i_chk_valid) begin
      unique case (state_q)
        StSearch: begin
          if (bus.i_chk_data != '0) begin
            expected_d  = step(bus.i_chk_data);
            match_cnt_d = '0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (bus.i_chk_data == expected_q) begin
            expected_d = step(bus.i_chk_data);
            if (match_cnt_q == MatchLast) begin
              state_d     = StLocked;
              match_cnt_d = '0;
              bad_cnt_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + MatchW'(1);
            end
          end else begin
            // Reseed from the word just seen; zero cannot seed a prediction.
            match_cnt_d = '0;
            if (bus.i_chk_data == '0) state_d = StSearch;
            else                      expected_d = step(bus.i_chk_data);
          end
        end
        StLocked: begin
          // Free-run the prediction so one bad word does not derail it.
          expected_d = step(expected_q);
          if (bus.i_chk_data == expected_q) begin
            bad_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
            if (bad_cnt_q == BadLast) begin
              state_d   = StSearch;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BadW'(1);
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end

    lock_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StSearch;
      expected_q  <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      lock_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      lock_q      <= lock_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.o_lock      = lock_q;
  assign bus.o_err_pulse = err_pulse_q;
  assign bus.o_err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_prbs_gen_check.sv
// Self-checking bench for lfsr_prbs_gen_check: directed scenarios plus
// randomized traffic, compared against a word-level behavioural model.
module tb_lfsr_prbs_gen_check;

  localparam int unsigned MSearch = 0;
  localparam int unsigned MVerify = 1;
  localparam int unsigned MLocked = 2;

  typedef struct {
    int unsigned width;
    int unsigned taps;
    int unsigned lock_cnt;
    int unsigned unlock_cnt;
    int unsigned errw;
  } cfg_t;

  typedef struct {
    int unsigned lfsr;
    int unsigned mode;
    int unsigned exp;
    int unsigned good;
    int unsigned bad;
    int unsigned errs;
    bit          pulse;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Stimulus shared by both 8-bit instances
  logic       srst = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       valid = 1'b0;
  logic       chk_valid = 1'b0;
  logic [7:0] mask8 = 8'h00;
  logic [7:0] mask_s = 8'h00;
  // 16-bit instance, plain loopback
  logic        srst16 = 1'b0;
  logic [15:0] seed16 = 16'h0000;
  logic        valid16 = 1'b0;

  lfsr_prbs_gen_check_if #(.WIDTH(8),  .ERR_W(16)) if8 ();
  lfsr_prbs_gen_check_if #(.WIDTH(8),  .ERR_W(3))  ifs ();
  lfsr_prbs_gen_check_if #(.WIDTH(16), .ERR_W(16)) if16 ();

  assign if8.i_soft_reset = srst;
  assign if8.i_seed       = seed;
  assign if8.i_valid      = valid;
  assign if8.i_chk_valid  = chk_valid;
  assign if8.i_chk_data   = if8.o_lfsr ^ mask8;

  assign ifs.i_soft_reset = srst;
  assign ifs.i_seed       = seed;
  assign ifs.i_valid      = valid;
  assign ifs.i_chk_valid  = chk_valid;
  assign ifs.i_chk_data   = ifs.o_lfsr ^ mask_s;

  assign if16.i_soft_reset = srst16;
  assign if16.i_seed       = seed16;
  assign if16.i_valid      = valid16;
  assign if16.i_chk_valid  = valid16;
  assign if16.i_chk_data   = if16.o_lfsr;

  lfsr_prbs_gen_check u_dut8 (
    .clk   (clk),
    .i_rst (rst_n),
    .bus   (if8)
  );

  lfsr_prbs_gen_check #(.ERR_W(3), .UNLOCK_CNT(100)) u_dut_sat (
    .clk   (clk),
    .i_rst (rst_n),
    .bus   (ifs)
  );

  lfsr_prbs_gen_check #(.WIDTH(16), .TAPS(16'hB400)) u_dut16 (
    .clk   (clk),
    .i_rst (rst_n),
    .bus   (if16)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nxt(int unsigned s, cfg_t c);
    return (s / 2) ^ (((s % 2) == 1) ? c.taps : 0);
  endfunction

  function automatic mdl_t mdl_reset(cfg_t c);
    mdl_t m;
    m.lfsr  = (c.width == 32) ? 32'hFFFF_FFFF : (32'd1 << c.width) - 1;
    m.mode  = MSearch;
    m.exp   = 0;
    m.good  = 0;
    m.bad   = 0;
    m.errs  = 0;
    m.pulse = 1'b0;
    return m;
  endfunction

  // One clock edge: inputs as seen by the edge, chkd is the word the checker sees.
  function automatic mdl_t mdl_next(mdl_t m, cfg_t c, bit sr, int unsigned sd, bit v,
                                    bit cv, int unsigned chkd);
    mdl_t n;
    int unsigned all1, errmax;
    all1   = (c.width == 32) ? 32'hFFFF_FFFF : (32'd1 << c.width) - 1;
    errmax = (32'd1 << c.errw) - 1;
    n = m;
    n.pulse = 1'b0;
    if (sr) begin
      n.lfsr = ((sd & all1) == 0) ? all1 : (sd & all1);
      n.mode = MSearch;
      n.exp  = 0;
      n.good = 0;
      n.bad  = 0;
      n.errs = 0;
      return n;
    end
    if (v) n.lfsr = nxt(m.lfsr, c);
    if (cv) begin
      if (m.mode == MSearch) begin
        if (chkd != 0) begin
          n.exp  = nxt(chkd, c);
          n.good = 0;
          n.mode = MVerify;
        end
      end else if (m.mode == MVerify) begin
        if (chkd == m.exp) begin
          n.exp  = nxt(chkd, c);
          n.good = m.good + 1;
          if (n.good == c.lock_cnt) begin
            n.mode = MLocked;
            n.good = 0;
            n.bad  = 0;
          end
        end else if (chkd == 0) begin
          n.mode = MSearch;
          n.good = 0;
        end else begin
          n.exp  = nxt(chkd, c);
          n.good = 0;
        end
      end else begin
        n.exp = nxt(m.exp, c);
        if (chkd == m.exp) begin
          n.bad = 0;
        end else begin
          n.pulse = 1'b1;
          if (m.errs < errmax) n.errs = m.errs + 1;
          n.bad = m.bad + 1;
          if (n.bad == c.unlock_cnt) begin
            n.mode = MSearch;
            n.bad  = 0;
          end
        end
      end
    end
    return n;
  endfunction

  cfg_t cfg8, cfgs, cfg16;
  mdl_t m8, ms, m16;

  task automatic cmp8();
    check_eq("lfsr8",  32'(if8.o_lfsr),      m8.lfsr);
    check_eq("lock8",  32'(if8.o_lock),      32'(m8.mode == MLocked));
    check_eq("pulse8", 32'(if8.o_err_pulse), 32'(m8.pulse));
    check_eq("errs8",  32'(if8.o_err_count), m8.errs);
    check_eq("lfsrS",  32'(ifs.o_lfsr),      ms.lfsr);
    check_eq("lockS",  32'(ifs.o_lock),      32'(ms.mode == MLocked));
    check_eq("pulseS", 32'(ifs.o_err_pulse), 32'(ms.pulse));
    check_eq("errsS",  32'(ifs.o_err_count), ms.errs);
  endtask

  task automatic tick8();
    int unsigned d8, ds;
    d8 = m8.lfsr ^ 32'(mask8);
    ds = ms.lfsr ^ 32'(mask_s);
    @(posedge clk);
    m8 = mdl_next(m8, cfg8, srst, 32'(seed), valid, chk_valid, d8);
    ms = mdl_next(ms, cfgs, srst, 32'(seed), valid, chk_valid, ds);
    #1;
    cmp8();
  endtask

  task automatic tick16();
    int unsigned d;
    d = m16.lfsr;
    @(posedge clk);
    m16 = mdl_next(m16, cfg16, srst16, 32'(seed16), valid16, valid16, d);
    #1;
    check_eq("lfsr16", 32'(if16.o_lfsr),      m16.lfsr);
    check_eq("lock16", 32'(if16.o_lock),      32'(m16.mode == MLocked));
    check_eq("errs16", 32'(if16.o_err_count), m16.errs);
  endtask

  task automatic soft_load(input logic [7:0] s);
    srst = 1'b1; seed = s; valid = 1'b0; chk_valid = 1'b0; mask8 = 0; mask_s = 0;
    tick8();
    srst = 1'b0;
  endtask

  logic [7:0] seq_ref [5];

  initial begin
    int unsigned ret, lock_word, pulses;
    bit zero_seen;
    cfg8  = '{width: 8,  taps: 32'hB8,   lock_cnt: 4, unlock_cnt: 4,   errw: 16};
    cfgs  = '{width: 8,  taps: 32'hB8,   lock_cnt: 4, unlock_cnt: 100, errw: 3};
    cfg16 = '{width: 16, taps: 32'hB400, lock_cnt: 4, unlock_cnt: 4,   errw: 16};
    seq_ref = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

    // Reset state
    #2 rst_n = 1'b0;
    m8 = mdl_reset(cfg8); ms = mdl_reset(cfgs); m16 = mdl_reset(cfg16);
    #1;
    check_eq("rst_lfsr", 32'(if8.o_lfsr), 32'hFF);
    check_eq("rst_lock", 32'(if8.o_lock), 0);
    check_eq("rst_errs", 32'(if8.o_err_count), 0);
    check_eq("rst_pulse", 32'(if8.o_err_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed 01 sequence, holding between pulses
    soft_load(8'h01);
    check_eq("seed01", 32'(if8.o_lfsr), 32'h01);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; tick8();
      check_eq("seq", 32'(if8.o_lfsr), 32'(seq_ref[i]));
      valid = 1'b0; tick8();
      check_eq("hold", 32'(if8.o_lfsr), 32'(seq_ref[i]));
    end

    // Zero seed with simultaneous valid: all ones, no advance
    srst = 1'b1; seed = 8'h00; valid = 1'b1;
    tick8();
    check_eq("zero_seed", 32'(if8.o_lfsr), 32'hFF);
    srst = 1'b0; valid = 1'b0;

    // Period from A5
    soft_load(8'hA5);
    ret = 0; zero_seen = 1'b0;
    valid = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick8();
      if (if8.o_lfsr == 8'hA5 && ret == 0) ret = i;
      if (if8.o_lfsr == 8'h00) zero_seen = 1'b1;
    end
    valid = 1'b0;
    check_eq("period", ret, 255);
    check_eq("never_zero", 32'(zero_seen), 0);

    // Loopback lock from seed 01, then 1000 clean words
    soft_load(8'h01);
    valid = 1'b1; chk_valid = 1'b1;
    lock_word = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick8();
      if (if8.o_lock && lock_word == 0) lock_word = i;
    end
    check_eq("lock_word", lock_word, 5);
    check_eq("clean_errs", 32'(if8.o_err_count), 0);

    // Single bit-3 error while locked
    pulses = 0;
    mask8 = 8'h08; mask_s = 8'h08;
    tick8();
    pulses += 32'(if8.o_err_pulse);
    mask8 = 0; mask_s = 0;
    for (int i = 0; i < 3; i++) begin
      tick8();
      pulses += 32'(if8.o_err_pulse);
    end
    check_eq("one_pulse", pulses, 1);
    check_eq("one_err", 32'(if8.o_err_count), 1);
    check_eq("still_lock", 32'(if8.o_lock), 1);

    // Four consecutive bad words force unlock, then relock in 5 clean words
    mask8 = 8'h08; mask_s = 8'h08;
    for (int i = 0; i < 4; i++) tick8();
    mask8 = 0; mask_s = 0;
    check_eq("five_errs", 32'(if8.o_err_count), 5);
    check_eq("unlocked", 32'(if8.o_lock), 0);
    lock_word = 0;
    for (int i = 1; i <= 8; i++) begin
      tick8();
      if (if8.o_lock && lock_word == 0) lock_word = i;
    end
    check_eq("relock_word", lock_word, 5);

    // Saturation on the ERR_W=3 instance: alternate bad and good words
    soft_load(8'h01);
    valid = 1'b1; chk_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick8();
    check_eq("sat_locked", 32'(ifs.o_lock), 1);
    for (int i = 0; i < 20; i++) begin
      mask_s = 8'h01; mask8 = 8'h01; tick8();
      mask_s = 8'h00; mask8 = 8'h00; tick8();
    end
    check_eq("sat_count", 32'(ifs.o_err_count), 7);
    check_eq("sat_lock", 32'(ifs.o_lock), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      valid     = ($urandom_range(0, 3) != 0);
      chk_valid = ($urandom_range(0, 9) == 0) ? ~valid : valid;
      mask8     = ($urandom_range(0, 39) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      mask_s    = mask8;
      srst      = ($urandom_range(0, 399) == 0);
      seed      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tick8();
    end
    srst = 1'b0;

    // Asynchronous reset while locked with a nonzero error count
    soft_load(8'($urandom_range(1, 255)));
    valid = 1'b1; chk_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick8();
    mask8 = 8'h10; mask_s = 8'h10; tick8();
    mask8 = 0; mask_s = 0; tick8();
    check_eq("pre_rst_errs", 32'(if8.o_err_count), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    m8 = mdl_reset(cfg8); ms = mdl_reset(cfgs); m16 = mdl_reset(cfg16);
    #1;
    check_eq("arst_lfsr", 32'(if8.o_lfsr), 32'hFF);
    check_eq("arst_lock", 32'(if8.o_lock), 0);
    check_eq("arst_errs", 32'(if8.o_err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lock_word = 0;
    for (int i = 1; i <= 8; i++) begin
      tick8();
      if (if8.o_lock && lock_word == 0) lock_word = i;
    end
    check_eq("post_rst_lock", lock_word, 5);
    valid = 1'b0; chk_valid = 1'b0;

    // 16-bit maximal-length loopback
    srst16 = 1'b1; seed16 = 16'h1234;
    tick16();
    srst16 = 1'b0; valid16 = 1'b1;
    lock_word = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick16();
      if (if16.o_lock && lock_word == 0) lock_word = i;
    end
    valid16 = 1'b0;
    check_eq("lock16_word", lock_word, 5);
    check_eq("period16", 32'(if16.o_lfsr), 32'h1234);
    check_eq("errs16_end", 32'(if16.o_err_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
